// File: rtl/fifo_reader.sv
// fifo_reader: pops bytes from a synchronous FIFO into a 2-entry buffer and presents them
// as a valid/ready byte stream with a packet-boundary flag. Optional macro FIFO_READER_PARITY_EN adds m_par.
module fifo_reader #(
    parameter int PKT_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic       fifo_wbusy,
    input  logic [7:0] fifo_o,
    output logic       fifo_ren,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last
`ifdef FIFO_READER_PARITY_EN
    ,
    output logic       m_par
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] occ_r;
    logic [1:0] occ_nxt_s;
    logic       inflight_r;
    logic [7:0] data0_r;
    logic [7:0] data1_r;
    logic [7:0] data0_nxt_s;
    logic [7:0] data1_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       m_valid_r;
    logic       m_last_r;
    logic       valid_nxt_s;
    logic       pop_s;
    logic       hs_s;
    logic       cap_s;
    logic [2:0] level_s;
    logic       pop_allow_s;

    // The byte popped on the previous edge is on fifo_o now and is captured at this edge.
    assign hs_s    = m_valid_r && m_ready;
    assign cap_s   = inflight_r;
    assign level_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, hs_s};
    assign fifo_ren = rst && en && !fifo_empty && pop_allow_s;
    assign pop_s   = fifo_ren && !fifo_empty && !fifo_wbusy;

    assign m_data  = data0_r;
    assign m_valid = m_valid_r;
    assign m_last  = m_last_r;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if ((occ_r == 2'd2) && !m_ready) begin
                    state_nxt_s = HOLD;
                end else if ((occ_nxt_s == 2'd0) && !pop_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            HOLD: begin
                if (hs_s) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: a pop is allowed only if buffered + in-flight bytes leave room after this cycle
    always_comb begin
        pop_allow_s = 1'b0;
        case (state_r)
            IDLE:    pop_allow_s = 1'b1;
            STREAM:  pop_allow_s = (level_s < 3'd2);
            HOLD:    pop_allow_s = hs_s;
            default: pop_allow_s = 1'b0;
        endcase
    end

    // Buffer update: dequeue on handshake, enqueue on capture, both keeps occupancy
    always_comb begin
        occ_nxt_s   = occ_r;
        data0_nxt_s = data0_r;
        data1_nxt_s = data1_r;
        if (hs_s && cap_s) begin
            if (occ_r == 2'd2) begin
                data0_nxt_s = data1_r;
                data1_nxt_s = fifo_o;
            end else begin
                data0_nxt_s = fifo_o;
            end
        end else if (hs_s) begin
            occ_nxt_s   = occ_r - 2'd1;
            data0_nxt_s = data1_r;
        end else if (cap_s) begin
            occ_nxt_s = occ_r + 2'd1;
            if (occ_r == 2'd0) begin
                data0_nxt_s = fifo_o;
            end else begin
                data1_nxt_s = fifo_o;
            end
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    // Packet position counter advances per handshake
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (hs_s) begin
            if (cnt_r == LAST_IDX) begin
                cnt_nxt_s = 8'd0;
            end else begin
                cnt_nxt_s = cnt_r + 8'd1;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    assign valid_nxt_s = (occ_nxt_s != 2'd0);

    // Datapath registers; reset also drops any in-flight byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            data0_r    <= 8'd0;
            data1_r    <= 8'd0;
            cnt_r      <= 8'd0;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
        end else begin
            occ_r      <= occ_nxt_s;
            inflight_r <= pop_s;
            data0_r    <= data0_nxt_s;
            data1_r    <= data1_nxt_s;
            cnt_r      <= cnt_nxt_s;
            m_valid_r  <= valid_nxt_s;
            m_last_r   <= valid_nxt_s && (cnt_nxt_s == LAST_IDX);
        end
    end

`ifdef FIFO_READER_PARITY_EN
    logic m_par_r;

    // Parity tracks the head byte and is forced low when nothing is valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_par_r <= 1'b0;
        end else begin
            m_par_r <= valid_nxt_s && odd_parity(data0_nxt_s);
        end
    end

    assign m_par = m_par_r;
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter: PKT_LEN, 16, bytes per packet (legal 2..255).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: en  input  1  high permits new FIFO pops; low stops pops, buffered bytes still delivered.
REQ-005 SHALL have port: fifo_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port: fifo_wbusy  input  1  FIFO accepted a write this cycle; a pop requested this cycle is not honoured.
REQ-007 SHALL have port: fifo_o  input  8  FIFO read data, valid in the cycle after an honoured pop.
REQ-008 SHALL have port: fifo_ren  output  1  pop request to FIFO.
REQ-009 SHALL have port: m_data  output  8  stream byte.
REQ-010 SHALL have port: m_valid  output  1  m_data valid.
REQ-011 SHALL have port: m_ready  input  1  downstream accepts; handshake = m_valid && m_ready.
REQ-012 SHALL have port: m_last  output  1  current byte is the PKT_LEN-th byte of its packet.

Function
REQ-013 SHALL define honoured pop = fifo_ren && !fifo_empty && !fifo_wbusy, sampled at the rising edge.
REQ-014 SHALL set a 1-bit in-flight flag after each honoured pop and capture fifo_o into the output buffer on the next edge, then clear the flag.
REQ-015 SHALL hold captured bytes in a 2-entry in-order output buffer; m_data/m_valid driven from the head entry.
REQ-016 SHALL assert fifo_ren combinationally only when en && !fifo_empty && (occupancy + in-flight - handshake-this-cycle) < 2.
REQ-017 SHALL sustain one byte per cycle when the FIFO is non-empty, fifo_wbusy low and m_ready held high.
REQ-018 SHALL hold m_data and m_valid stable while m_valid && !m_ready; no byte dropped or duplicated.
REQ-019 SHALL treat a dropped pop (fifo_wbusy or fifo_empty high with fifo_ren high) as not issued: no in-flight set, no capture.
REQ-020 SHALL, on a handshake and capture in the same cycle, dequeue head and enqueue new byte so occupancy is unchanged.
REQ-021 SHALL keep an 8-bit packet counter 0..PKT_LEN-1 that increments on each handshake and wraps to 0 after the byte with counter = PKT_LEN-1.
REQ-022 SHALL assert m_last when m_valid && counter == PKT_LEN-1, stable with m_data.
REQ-023 SHALL implement state machine IDLE (buffer empty, no in-flight), STREAM (bytes buffered or in flight), HOLD (buffer full, m_ready low); IDLE->STREAM on honoured pop; STREAM->HOLD when occupancy 2 and !m_ready; HOLD->STREAM on handshake; STREAM->IDLE when buffer empties with no in-flight.
REQ-024 SHALL, with en dropped mid-stream, complete delivery of the in-flight byte and buffered bytes and issue no further pops.

Reset
REQ-025 SHALL on rst low at an edge clear fifo_ren, m_valid, m_last, m_data to 0, occupancy, in-flight and packet counter to 0, state to IDLE.
REQ-026 SHALL discard a byte whose pop was honoured in the cycle reset was asserted; fifo_ren SHALL be 0 while rst is low.

Configuration
REQ-027 SHALL, with macro FIFO_READER_PARITY_EN defined, add output m_par (1 bit), odd parity of m_data (XOR of m_data bits inverted), valid with m_valid, 0 in reset.
REQ-028 SHALL, without FIFO_READER_PARITY_EN, have no m_par port and otherwise identical behaviour.

Verification
REQ-029 SHALL cover: FIFO holds 0x11..0x14, m_ready=1, en=1 -> fifo_ren 4 consecutive cycles, m_data 0x11..0x14 on consecutive cycles starting 2 cycles after first pop.
REQ-030 SHALL cover: 3 bytes queued, m_ready=0 -> exactly 2 pops, fifo_ren low thereafter, m_data holds first byte; raise m_ready -> all 3 bytes delivered in order.
REQ-031 SHALL cover: fifo_wbusy=1 in the cycle of a requested pop -> no capture next cycle, pop retried, no duplicate or lost byte.
REQ-032 SHALL cover: PKT_LEN=4, 9 bytes streamed -> m_last high on bytes 4 and 8 only; counter 1 after byte 9.
REQ-033 SHALL cover: rst low for 1 cycle while a byte is in flight and buffer holds 1 -> m_valid=0 next cycle, in-flight byte never appears on m_data.
REQ-034 SHALL cover: FIFO_READER_PARITY_EN defined, m_data=0x03 -> m_par=1; m_data=0x07 -> m_par=0.
